// File: rtl/bnn_output_scanner.sv
// rtl/bnn_output_scanner.sv - scans BNN result words and compresses them into a MISR signature
//
// Purpose: walks sel_addr over NUM_WORDS result words of the BNN wrapper,
// samples each returned word READ_LAT cycles later and folds it into a
// SIG_W-bit MISR. Optional argmax tracker enabled by BNN_SCAN_MAXTRACK_EN.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      pulse, begins one scan pass (only honoured in IDLE)
//   sel_addr   word select to wrapper
//   sel_data   selected word from wrapper
//   busy       high during SCAN and DRAIN
//   done       one-cycle pulse when signature is final
//   signature  MISR value, stable from done until next start
//   max_val    (BNN_SCAN_MAXTRACK_EN) largest unsigned sample
//   max_idx    (BNN_SCAN_MAXTRACK_EN) index of max_val
module bnn_output_scanner #(
  parameter int                 NUM_WORDS = 64,
  parameter int                 ADDR_W    = 6,
  parameter int                 DATA_W    = 16,
  parameter int                 SIG_W     = 32,
  parameter logic [SIG_W-1:0]   POLY      = 32'h04C11DB7,
  parameter logic [SIG_W-1:0]   SEED      = 32'hFFFFFFFF,
  parameter int                 READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] sel_addr,
  input  logic [DATA_W-1:0] sel_data,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature
`ifdef BNN_SCAN_MAXTRACK_EN
  ,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_idx
`endif
);

  localparam int                CNT_W    = $clog2(READ_LAT + 1);
  localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(NUM_WORDS - 1);
  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [READ_LAT-1:0] vld;
  logic [CNT_W-1:0]  drain_cnt;
  logic [SIG_W-1:0]  misr_next;

  // One MISR step: shift with polynomial feedback, then fold in the
  // zero-extended sample.
  assign misr_next = {signature[SIG_W-2:0], 1'b0}
                   ^ (signature[SIG_W-1] ? POLY : '0)
                   ^ SIG_W'(sel_data);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) state_next = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (sel_addr == LAST) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == LAT_LAST) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

`ifdef BNN_SCAN_MAXTRACK_EN
  logic [ADDR_W-1:0] samp_idx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_addr  <= '0;
      vld       <= '0;
      drain_cnt <= '0;
      signature <= '0;
`ifdef BNN_SCAN_MAXTRACK_EN
      max_val   <= '0;
      max_idx   <= '0;
      samp_idx  <= '0;
`endif
    end else begin
      // vld[k] marks that the address issued k+1 cycles ago was a real
      // scan address; the oldest tap lines up with its returned data.
      vld[0] <= (state == SCAN);
      for (int i = 1; i < READ_LAT; i++) vld[i] <= vld[i-1];

      if (vld[READ_LAT-1]) begin
        signature <= misr_next;
`ifdef BNN_SCAN_MAXTRACK_EN
        samp_idx <= samp_idx + 1'b1;
        // Strictly greater keeps the lowest index on ties.
        if (sel_data > max_val) begin
          max_val <= sel_data;
          max_idx <= samp_idx;
        end
`endif
      end

      case (state)
        IDLE: begin
          sel_addr <= '0;
          if (start) begin
            signature <= SEED;
`ifdef BNN_SCAN_MAXTRACK_EN
            max_val  <= '0;
            max_idx  <= '0;
            samp_idx <= '0;
`endif
          end
        end
        SCAN: begin
          drain_cnt <= '0;
          if (sel_addr != LAST) sel_addr <= sel_addr + 1'b1;
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        DONE:  sel_addr  <= '0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_output_scanner.sv
// tb/tb_bnn_output_scanner.sv - directed self-checking bench for bnn_output_scanner
module tb_bnn_output_scanner;

  localparam logic [31:0] POLY = 32'h04C11DB7;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start3;
  logic        maxdata;
  logic        zero3;

  logic [5:0]  sel_addr, sel_addr3;
  logic [15:0] sel_data, sel_data3, p1, p2;
  logic        busy, done, busy3, done3;
  logic [31:0] signature, signature3;
`ifdef BNN_SCAN_MAXTRACK_EN
  logic [15:0] max_val, max_val3;
  logic [5:0]  max_idx, max_idx3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bnn_output_scanner u_dut (
    .clk(clk), .rst(rst), .start(start), .sel_addr(sel_addr), .sel_data(sel_data),
    .busy(busy), .done(done), .signature(signature)
`ifdef BNN_SCAN_MAXTRACK_EN
    , .max_val(max_val), .max_idx(max_idx)
`endif
  );

  bnn_output_scanner #(.SEED(32'h0), .READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .start(start3), .sel_addr(sel_addr3), .sel_data(sel_data3),
    .busy(busy3), .done(done3), .signature(signature3)
`ifdef BNN_SCAN_MAXTRACK_EN
    , .max_val(max_val3), .max_idx(max_idx3)
`endif
  );

  // Wrapper stubs: 1-cycle and 3-cycle read latency.
  always @(posedge clk) begin
    if (maxdata && (sel_addr == 6'd5 || sel_addr == 6'd40)) sel_data <= 16'hFFFF;
    else                                                  sel_data <= {10'b0, sel_addr};
    p1        <= zero3 ? 16'h0 : {10'b0, sel_addr3} * 16'd3;
    p2        <= p1;
    sel_data3 <= p2;
  end

  function automatic logic [31:0] step(input logic [31:0] s, input logic [15:0] d);
    return ((s << 1) ^ (s[31] ? POLY : 32'h0)) ^ {16'h0, d};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one pass on the chosen instance with start high in cycle 0 and
  // records when done pulsed, how often, and the values seen at done.
  task automatic run_pass(input bit lat3, output int dcyc, output int npulse,
                          output logic [31:0] sig, output int overlap,
                          output logic [15:0] mval, output logic [5:0] midx);
    dcyc = -1; npulse = 0; sig = 'x; overlap = 0; mval = 'x; midx = 'x;
    if (lat3) start3 = 1'b1; else start = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick;
      start = 1'b0; start3 = 1'b0;
      if (lat3 ? (busy3 && done3) : (busy && done)) overlap++;
      if (lat3 ? done3 : done) begin
        dcyc = c;
        npulse++;
        sig = lat3 ? signature3 : signature;
`ifdef BNN_SCAN_MAXTRACK_EN
        mval = lat3 ? max_val3 : max_val;
        midx = lat3 ? max_idx3 : max_idx;
`endif
      end
    end
  endtask

  logic [31:0] exp_a, exp_m, exp_l3, s;
  int          dcyc, npulse, overlap, seen;
  logic [15:0] mval;
  logic [5:0]  midx;

  initial begin
    exp_a = 32'hFFFFFFFF;
    for (int i = 0; i < 64; i++) exp_a = step(exp_a, 16'(i));
    exp_m = 32'hFFFFFFFF;
    for (int i = 0; i < 64; i++) exp_m = step(exp_m, (i == 5 || i == 40) ? 16'hFFFF : 16'(i));
    exp_l3 = 32'h0;
    for (int i = 0; i < 64; i++) exp_l3 = step(exp_l3, 16'(i * 3));

    rst = 1'b1; start = 1'b0; start3 = 1'b0; maxdata = 1'b0; zero3 = 1'b0;
    repeat (3) tick;
    chk("rst_sel_addr", 32'(sel_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_signature", signature, 32'h0);
    chk("rst_lat3_signature", signature3, 32'h0);
    rst = 1'b0;
    tick;

    // Pass with extra starts in cycles 10 (busy) and 66 (DONE), then a
    // start in cycle 68 (IDLE) launching a second pass.
    for (int n = 0; n < 140; n++) begin
      start = (n == 0 || n == 10 || n == 66 || n == 68);
      tick;
      start = 1'b0;
      chk($sformatf("busy_c%0d", n + 1), 32'(busy),
          32'((n + 1 <= 65) || (n + 1 >= 69 && n + 1 <= 133)));
      chk($sformatf("done_c%0d", n + 1), 32'(done), 32'(n + 1 == 66 || n + 1 == 134));
      if (n + 1 == 1)   chk("addr_c1", 32'(sel_addr), 32'd0);
      if (n + 1 == 64)  chk("addr_c64", 32'(sel_addr), 32'd63);
      if (n + 1 == 66)  chk("addr_hold_done", 32'(sel_addr), 32'd63);
      if (n + 1 == 66)  chk("sig_pass1", signature, exp_a);
      if (n + 1 == 67)  chk("addr_idle", 32'(sel_addr), 32'd0);
      if (n + 1 == 68)  chk("sig_stable", signature, exp_a);
      if (n + 1 == 134) chk("sig_pass2", signature, exp_a);
    end

    // Reset in cycle 30 of a pass aborts it.
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      tick;
      start = 1'b0;
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_sel_addr", 32'(sel_addr), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_signature", signature, 32'h0);
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      tick;
      if (done) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'h0);
    run_pass(1'b0, dcyc, npulse, s, overlap, mval, midx);
    chk("after_abort_done_cycle", 32'(dcyc), 32'd66);
    chk("after_abort_sig", s, exp_a);
    chk("after_abort_overlap", 32'(overlap), 32'h0);

    // SEED=0 and all-zero data gives zero, twice.
    zero3 = 1'b1;
    run_pass(1'b1, dcyc, npulse, s, overlap, mval, midx);
    chk("zero_done_cycle", 32'(dcyc), 32'd68);
    chk("zero_sig1", s, 32'h0);
    run_pass(1'b1, dcyc, npulse, s, overlap, mval, midx);
    chk("zero_sig2", s, 32'h0);

    // READ_LAT=3 with data = addr*3.
    zero3 = 1'b0;
    run_pass(1'b1, dcyc, npulse, s, overlap, mval, midx);
    chk("lat3_done_cycle", 32'(dcyc), 32'd68);
    chk("lat3_done_pulses", 32'(npulse), 32'd1);
    chk("lat3_sig", s, exp_l3);
    chk("lat3_overlap", 32'(overlap), 32'h0);

    // Two 0xFFFF words: tie keeps the lower index.
    maxdata = 1'b1;
    run_pass(1'b0, dcyc, npulse, s, overlap, mval, midx);
    chk("maxdata_sig", s, exp_m);
`ifdef BNN_SCAN_MAXTRACK_EN
    chk("max_val", 32'(mval), 32'h0000FFFF);
    chk("max_idx", 32'(midx), 32'd5);
`endif
    maxdata = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
